x2z_block_sequencer: RTL and testbench
======================================

Name: x2z_block_sequencer

Overview:
Sequences one ROWS x COLS sample block into the x2zArray transform datapath. The array has no stall input, so each row is staged in a local row buffer and issued as COLS back-to-back cycles. The block generates the sumDiffSel/load pattern and the coefficient row select, then drains the array by counting its valid pulses before signalling completion. It sits between the sample-stream source and the x2zArray instance.

Parameters:
DATA_WIDTH, 8, sample width; equals the x2zArray data width.
ROWS, 8, rows per block.
COLS, 8, samples per row; even, at least 2.
OUT_PER_BLOCK, 64, number of arr_valid pulses expected per block.
DRAIN_TIMEOUT, 256, maximum DRAIN cycles before the timeout error.

Ports:
clk  in  1  clock; all logic on the rising edge.
rst  in  1  synchronous, active-high reset.
start  in  1  single-cycle block start; honoured only in IDLE.
busy  out  1  high in every state except IDLE.
done  out  1  one-cycle pulse at the end of a block.
timeout_err  out  1  sticky; cleared by rst or by an accepted start.
in_data  in  DATA_WIDTH  input sample.
in_valid  in  1  in_data is valid.
in_ready  out  1  sequencer accepts a sample this cycle.
arr_x  out  DATA_WIDTH  sample to array x.
arr_sum_diff_sel  out  1  to array sumDiffSel.
arr_load  out  1  to array load.
arr_coef_row  out  clog2(ROWS)  row index for the coefficient select.
arr_valid  in  1  array valid.

Behaviour:
- Reset: state=IDLE; row_cnt, col_cnt, out_cnt and timer=0; row buffer cleared to 0.
- Reset values of outputs: busy=0, done=0, timeout_err=0, in_ready=0, arr_x=0, arr_sum_diff_sel=0, arr_load=0, arr_coef_row=0.
- A reset in any state aborts the block immediately. No done pulse is produced.
- States: IDLE, FILL, ISSUE, DRAIN, DONE.
- IDLE:
  - start=1 moves to FILL and clears row_cnt, col_cnt, out_cnt and timeout_err.
  - start outside IDLE is ignored.
- FILL:
  - in_ready=1.
  - Each cycle with in_valid&in_ready, in_data is written to buf[col_cnt] and col_cnt increments.
  - The cycle that accepts sample COLS-1 clears col_cnt and moves to ISSUE.
  - in_valid gaps only delay FILL; they never reach the array.
- ISSUE:
  - Lasts exactly COLS consecutive cycles, c = 0..COLS-1. in_ready=0.
  - Outputs are driven combinationally from registers: arr_x=buf[c], arr_sum_diff_sel=c[0], arr_load=(c<2), arr_coef_row=row_cnt.
  - On c=COLS-1: if row_cnt=ROWS-1, go to DRAIN and clear timer; otherwise increment row_cnt and go to FILL.
- Outside ISSUE: arr_x=0, arr_sum_diff_sel=0, arr_load=0. arr_coef_row holds the row_cnt value.
- out_cnt:
  - Increments on arr_valid in any non-IDLE state.
  - Saturates at OUT_PER_BLOCK.
  - Pulses arriving before DRAIN count toward the total.
- DRAIN:
  - timer increments each cycle.
  - Leave for DONE when out_cnt reaches OUT_PER_BLOCK, including in the same cycle as the final arr_valid.
  - Also leave for DONE if timer reaches DRAIN_TIMEOUT-1. In that case timeout_err is set.
  - If both happen in the same cycle, the count wins and timeout_err is not set.
- DONE: done=1 for one cycle, then IDLE. busy=0 from the following cycle. A start in the DONE cycle is ignored.
- Latency:
  - First arr_load=1 occurs 1 cycle after the COLS-th accepted sample of a row.
  - Minimum block time from start to done is ROWS*2*COLS + 3 cycles, given OUT_PER_BLOCK pulses already counted.
- Widths: col_cnt is clog2(COLS) bits; row_cnt is clog2(ROWS) bits; timer is clog2(DRAIN_TIMEOUT) bits. The counters never wrap within a block.

Test Plan:
- Nominal: rst, then start, in_valid held 1, in_data = column index 0..7 for all 8 rows, arr_valid pulsed 64 times.
  -> Each ISSUE shows arr_x 0..7, sumDiffSel 0,1,0,1,..., load=1 only on c=0,1; arr_coef_row steps 0..7; one done pulse; timeout_err=0.
- Input bubbles: in_valid low for 3 cycles mid-row (after 4 samples).
  -> in_ready stays 1; arr_load/arr_x stay 0 during the gap; the issued row is still 8 contiguous cycles with the correct data.
- Timeout: only 60 arr_valid pulses.
  -> After 256 DRAIN cycles, done pulses and timeout_err=1 and holds.
  -> The next accepted start clears timeout_err.
- Start while busy: start asserted during FILL of row 3.
  -> No effect on row_cnt or data; a single done at the end of the block.
- Reset mid-ISSUE: rst high at c=4 of row 2.
  -> Next cycle, all outputs at reset values, busy=0, no done.
  -> A following start runs a full correct block.
- Simultaneous: the 64th arr_valid lands on DRAIN cycle 255.
  -> done pulses and timeout_err stays 0.

Source files
------------

// File: rtl/x2z_block_sequencer.sv
// Stages one ROWS x COLS sample block row by row and issues each row to the
// x2zArray as COLS contiguous cycles, then waits for the array's valid pulses.
module x2z_block_sequencer #(
   parameter int DATA_WIDTH    = 8,
   parameter int ROWS          = 8,
   parameter int COLS          = 8,
   parameter int OUT_PER_BLOCK = 64,
   parameter int DRAIN_TIMEOUT = 256,
   localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   output logic                  busy,
   output logic                  done,
   output logic                  timeout_err,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic [DATA_WIDTH-1:0] arr_x,
   output logic                  arr_sum_diff_sel,
   output logic                  arr_load,
   output logic [RW-1:0]         arr_coef_row,
   input  logic                  arr_valid
);

   localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
   localparam int TW = (DRAIN_TIMEOUT > 1) ? $clog2(DRAIN_TIMEOUT) : 1;
   localparam int OW = $clog2(OUT_PER_BLOCK + 1);

   localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);
   localparam logic [TW-1:0] T_LAST   = TW'(DRAIN_TIMEOUT - 1);
   localparam logic [OW-1:0] OUT_FULL = OW'(OUT_PER_BLOCK);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FILL,
      S_ISSUE,
      S_DRAIN,
      S_DONE
   } state_t;

   state_t                state_q, state_d;
   logic [RW-1:0]         row_cnt_q, row_cnt_d;
   logic [CW-1:0]         col_cnt_q, col_cnt_d;
   logic [OW-1:0]         out_cnt_q, out_cnt_d;
   logic [TW-1:0]         timer_q, timer_d;
   logic                  timeout_err_q, timeout_err_d;
   logic [DATA_WIDTH-1:0] row_buf_q [COLS];
   logic [DATA_WIDTH-1:0] row_buf_d [COLS];

   always_comb begin
      state_d          = state_q;
      row_cnt_d        = row_cnt_q;
      col_cnt_d        = col_cnt_q;
      out_cnt_d        = out_cnt_q;
      timer_d          = timer_q;
      timeout_err_d    = timeout_err_q;
      row_buf_d        = row_buf_q;
      busy             = (state_q != S_IDLE);
      done             = (state_q == S_DONE);
      in_ready         = (state_q == S_FILL);
      arr_x            = '0;
      arr_sum_diff_sel = 1'b0;
      arr_load         = 1'b0;
      arr_coef_row     = row_cnt_q;

      // Pulses that arrive while rows are still being issued count too.
      if (state_q != S_IDLE && arr_valid && out_cnt_q != OUT_FULL)
         out_cnt_d = out_cnt_q + 1'b1;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d       = S_FILL;
               row_cnt_d     = '0;
               col_cnt_d     = '0;
               out_cnt_d     = '0;
               timeout_err_d = 1'b0;
            end
         end
         S_FILL: begin
            if (in_valid) begin
               row_buf_d[col_cnt_q] = in_data;
               if (col_cnt_q == COL_LAST) begin
                  col_cnt_d = '0;
                  state_d   = S_ISSUE;
               end else begin
                  col_cnt_d = col_cnt_q + 1'b1;
               end
            end
         end
         S_ISSUE: begin
            arr_x            = row_buf_q[col_cnt_q];
            arr_sum_diff_sel = col_cnt_q[0];
            arr_load         = (col_cnt_q <= CW'(1));
            if (col_cnt_q == COL_LAST) begin
               col_cnt_d = '0;
               if (row_cnt_q == ROW_LAST) begin
                  state_d = S_DRAIN;
                  timer_d = '0;
               end else begin
                  row_cnt_d = row_cnt_q + 1'b1;
                  state_d   = S_FILL;
               end
            end else begin
               col_cnt_d = col_cnt_q + 1'b1;
            end
         end
         S_DRAIN: begin
            timer_d = timer_q + 1'b1;
            // A count reached on the last allowed cycle beats the timeout.
            if (out_cnt_d == OUT_FULL) begin
               state_d = S_DONE;
            end else if (timer_q == T_LAST) begin
               state_d       = S_DONE;
               timeout_err_d = 1'b1;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign timeout_err = timeout_err_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= S_IDLE;
         row_cnt_q     <= '0;
         col_cnt_q     <= '0;
         out_cnt_q     <= '0;
         timer_q       <= '0;
         timeout_err_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         row_cnt_q     <= row_cnt_d;
         col_cnt_q     <= col_cnt_d;
         out_cnt_q     <= out_cnt_d;
         timer_q       <= timer_d;
         timeout_err_q <= timeout_err_d;
      end
   end

   for (genvar gi = 0; gi < COLS; gi++) begin : g_row_buf
      always_ff @(posedge clk) begin
         if (rst) row_buf_q[gi] <= '0;
         else     row_buf_q[gi] <= row_buf_d[gi];
      end
   end

endmodule

// File: tb/tb_x2z_block_sequencer.sv
// Directed bench for x2z_block_sequencer: nominal block, bubbles, timeout,
// start while busy, reset mid-issue and count/timeout collision.
module tb_x2z_block_sequencer;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic       busy;
   logic       done;
   logic       timeout_err;
   logic [7:0] in_data;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] arr_x;
   logic       arr_sum_diff_sel;
   logic       arr_load;
   logic [2:0] arr_coef_row;
   logic       arr_valid;

   int    total = 0;
   int    bad = 0;
   int    pulses_left = 0;
   string phase = "init";

   x2z_block_sequencer #(
      .DATA_WIDTH(8), .ROWS(8), .COLS(8), .OUT_PER_BLOCK(64), .DRAIN_TIMEOUT(256)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
      .timeout_err(timeout_err), .in_data(in_data), .in_valid(in_valid),
      .in_ready(in_ready), .arr_x(arr_x), .arr_sum_diff_sel(arr_sum_diff_sel),
      .arr_load(arr_load), .arr_coef_row(arr_coef_row), .arr_valid(arr_valid)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached in phase %s", phase);
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      total++;
      assert (obs === exp_v) else begin
         bad++;
         $error("FAIL %s/%s observed=%0d expected=%0d", phase, tag, obs, exp_v);
      end
   endtask

   function automatic logic [7:0] sample(input int base, input int rstep, input int r, input int c);
      return 8'((base + r * rstep + c) & 255);
   endfunction

   task automatic check_reset_outputs();
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_err", timeout_err, 0);
      chk("rst_ready", in_ready, 0);
      chk("rst_x", arr_x, 0);
      chk("rst_sel", arr_sum_diff_sel, 0);
      chk("rst_load", arr_load, 0);
      chk("rst_row", arr_coef_row, 0);
   endtask

   task automatic fill_row(input int r, input int base, input int rstep, input bit gap, input bit start_pulse);
      for (int c = 0; c < 8; c++) begin
         if (gap && c == 4) begin
            for (int g = 0; g < 3; g++) begin
               @(negedge clk);
               in_valid = 1'b0;
               start = 1'b0;
               chk("gap_ready", in_ready, 1);
               chk("gap_load", arr_load, 0);
               chk("gap_x", arr_x, 0);
            end
         end
         @(negedge clk);
         if (r == 0 && c == 0) begin
            chk("start_busy", busy, 1);
            chk("start_err_clr", timeout_err, 0);
         end
         chk("fill_ready", in_ready, 1);
         chk("fill_load", arr_load, 0);
         chk("fill_x", arr_x, 0);
         chk("fill_row", arr_coef_row, r);
         arr_valid = 1'b0;
         in_valid = 1'b1;
         in_data = sample(base, rstep, r, c);
         start = start_pulse && (c == 2);
      end
   endtask

   task automatic issue_row(input int r, input int base, input int rstep, input int last_c);
      for (int c = 0; c <= last_c; c++) begin
         @(negedge clk);
         in_valid = 1'b0;
         start = 1'b0;
         chk("iss_x", arr_x, sample(base, rstep, r, c));
         chk("iss_sel", arr_sum_diff_sel, c % 2);
         chk("iss_load", arr_load, (c < 2) ? 1 : 0);
         chk("iss_row", arr_coef_row, r);
         chk("iss_ready", in_ready, 0);
         chk("iss_done", done, 0);
         arr_valid = (pulses_left > 0);
         if (pulses_left > 0) pulses_left--;
      end
   endtask

   task automatic run_block(input int base, input int rstep, input int gap_row, input int start_row,
                            input int npulses, input int pulse_at, input int exp_n, input bit exp_err);
      int  done_n;
      bit  seen;
      @(negedge clk);
      chk("idle_busy", busy, 0);
      start = 1'b1;
      pulses_left = npulses;
      for (int r = 0; r < 8; r++) begin
         fill_row(r, base, rstep, r == gap_row, r == start_row);
         issue_row(r, base, rstep, 7);
      end
      seen = 1'b0;
      done_n = -1;
      for (int n = 0; n < 300; n++) begin
         @(negedge clk);
         arr_valid = (n == pulse_at);
         if (done === 1'b1) begin
            seen = 1'b1;
            done_n = n;
            arr_valid = 1'b0;
            break;
         end
      end
      chk("done_seen", seen, 1);
      chk("done_lat", done_n, exp_n);
      chk("done_busy", busy, 1);
      chk("done_err", timeout_err, exp_err);
      @(negedge clk);
      chk("post_done", done, 0);
      chk("post_busy", busy, 0);
      chk("post_err", timeout_err, exp_err);
   endtask

   initial begin
      rst = 1'b1;
      start = 1'b0;
      in_valid = 1'b0;
      in_data = '0;
      arr_valid = 1'b0;
      repeat (3) @(negedge clk);
      phase = "reset";
      check_reset_outputs();
      rst = 1'b0;

      phase = "nominal";
      run_block(0, 0, -1, -1, 64, -1, 1, 1'b0);

      phase = "bubbles";
      run_block(8'h10, 16, 5, -1, 64, -1, 1, 1'b0);

      phase = "timeout";
      run_block(8'h21, 7, -1, -1, 60, -1, 256, 1'b1);
      repeat (3) begin
         @(negedge clk);
         chk("err_hold", timeout_err, 1);
         chk("idle_done", done, 0);
      end

      phase = "start_busy";
      run_block(8'h40, 3, -1, 3, 64, -1, 1, 1'b0);
      repeat (3) begin
         @(negedge clk);
         chk("no_2nd_done", done, 0);
      end

      phase = "reset_mid_issue";
      @(negedge clk);
      start = 1'b1;
      pulses_left = 64;
      fill_row(0, 8'h80, 5, 1'b0, 1'b0);
      issue_row(0, 8'h80, 5, 7);
      fill_row(1, 8'h80, 5, 1'b0, 1'b0);
      issue_row(1, 8'h80, 5, 7);
      fill_row(2, 8'h80, 5, 1'b0, 1'b0);
      issue_row(2, 8'h80, 5, 4);
      rst = 1'b1;
      arr_valid = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      check_reset_outputs();
      repeat (3) begin
         @(negedge clk);
         chk("abort_done", done, 0);
         chk("abort_busy", busy, 0);
      end

      phase = "after_reset";
      run_block(8'h33, 9, -1, -1, 64, -1, 1, 1'b0);

      phase = "simultaneous";
      run_block(8'h05, 11, -1, -1, 63, 255, 256, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
